// File: rtl/axi_slv_pkg.sv
// Shared AXI slave memory types: burst/response codes, FSM states, latched command.
package axi_slv_pkg;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] FIXED = 2'b00;
  localparam logic [BURST_W-1:0] INCR  = 2'b01;
  localparam logic [BURST_W-1:0] WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} write_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         read_state_t;

  // Burst attributes captured on an address handshake.
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } burst_cmd_t;
endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI channel bundle between a master and the slave memory.
interface axi_slave_mem_if
  import axi_slv_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic               awvalid;
  logic [ID_W-1:0]    awid;
  logic [AW-1:0]      awaddr;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic               awready;

  logic               wvalid;
  logic [DW-1:0]      wdata;
  logic [DW/8-1:0]    wstrb;
  logic               wlast;
  logic               wready;

  logic               bvalid;
  logic [ID_W-1:0]    bid;
  logic               bready;

  logic               arvalid;
  logic [ID_W-1:0]    arid;
  logic [AW-1:0]      araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arready;

  logic               rvalid;
  logic [DW-1:0]      rdata;
  logic [ID_W-1:0]    rid;
  logic               rlast;
  logic [RESP_W-1:0]  rresp;
  logic               rready;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast,                    output wready,
    output bvalid, bid,                                    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rid, rlast, rresp,               input  rready
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input  awready,
    output wvalid, wdata, wstrb, wlast,                    input  wready,
    input  bvalid, bid,                                    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input  arready,
    input  rvalid, rdata, rid, rlast, rresp,               output rready
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0]      addr,
  input  logic [SIZE_W-1:0]  size,
  input  logic [LEN_W-1:0]   len,
  input  logic [BURST_W-1:0] burst,
  output logic [AW-1:0]      next_addr_c
);
  logic [AW-1:0] step;
  logic [AW-1:0] incr;
  logic [AW-1:0] wrap_mask;
  logic          wrap_ok;

  always_comb begin
    step      = AW'(1) << size;
    incr      = addr + step;
    wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    // Only 2/4/8/16-beat wraps are legal; anything else behaves as INCR.
    wrap_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    case (burst)
      FIXED:   next_addr_c = addr;
      WRAP:    next_addr_c = wrap_ok ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
      default: next_addr_c = incr;
    endcase
  end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave backed by a word-addressed memory; independent read and write FSMs.
module axi_slave_mem
  import axi_slv_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic            aclk,
  input  logic            aresetn,
  axi_slave_mem_if.slave  bus
);
  localparam int unsigned   IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW-1:0] MEM_BYTES = AW'(MEM_WORDS * 4);

  logic [DW-1:0] mem [MEM_WORDS];

  // Bursts end on beat count alone; wlast is accepted but ignored.
  logic unused;
  assign unused = bus.wlast;

  write_state_t     w_state, w_next;
  burst_cmd_t       w_cmd, w_cmd_d;
  logic [AW-1:0]    w_addr, w_addr_d, w_addr_nxt_c;
  logic [LEN_W-1:0] w_cnt, w_cnt_d;
  logic             awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]  bid_q, bid_d;
  logic             mem_we_c;

  read_state_t       r_state, r_next;
  burst_cmd_t        r_cmd, r_cmd_d;
  logic [AW-1:0]     r_addr, r_addr_d, r_addr_nxt_c, rd_addr_c;
  logic [LEN_W-1:0]  r_cnt, r_cnt_d;
  logic              arready_q, rvalid_q, rlast_q, rlast_d;
  logic [DW-1:0]     rdata_q, rdata_d, rd_word_c;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [RESP_W-1:0] rresp_q, rresp_d;
  logic              rd_ok_c;

  axi_burst_addr_gen #(.AW(AW)) u_wr_addr (
    .addr(w_addr), .size(w_cmd.size), .len(w_cmd.len), .burst(w_cmd.burst),
    .next_addr_c(w_addr_nxt_c)
  );

  axi_burst_addr_gen #(.AW(AW)) u_rd_addr (
    .addr(r_addr), .size(r_cmd.size), .len(r_cmd.len), .burst(r_cmd.burst),
    .next_addr_c(r_addr_nxt_c)
  );

  // Write FSM next-state and register inputs.
  always_comb begin
    w_next   = w_state;
    w_cmd_d  = w_cmd;
    w_addr_d = w_addr;
    w_cnt_d  = w_cnt;
    bid_d    = bid_q;
    mem_we_c = 1'b0;
    unique case (w_state)
      W_IDLE: if (bus.awvalid && awready_q) begin
        w_cmd_d  = '{id: bus.awid, len: bus.awlen, size: bus.awsize, burst: bus.awburst};
        w_addr_d = bus.awaddr;
        w_cnt_d  = '0;
        w_next   = W_DATA;
      end
      W_DATA: if (bus.wvalid && wready_q) begin
        mem_we_c = (w_addr < MEM_BYTES);
        w_addr_d = w_addr_nxt_c;
        w_cnt_d  = w_cnt + 4'd1;
        if (w_cnt == w_cmd.len) begin
          bid_d  = w_cmd.id;
          w_next = W_RESP;
        end
      end
      W_RESP: if (bus.bready && bvalid_q) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      w_cmd     <= '0;
      w_addr    <= '0;
      w_cnt     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      w_state   <= w_next;
      w_cmd     <= w_cmd_d;
      w_addr    <= w_addr_d;
      w_cnt     <= w_cnt_d;
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      bvalid_q  <= (w_next == W_RESP);
      bid_q     <= bid_d;
    end
  end

  // Byte-lane writes; storage is deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[w_addr[IW+1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // The word fetched is for the beat presented after the next clock edge.
  assign rd_addr_c = (r_state == R_IDLE) ? bus.araddr : r_addr_nxt_c;
  assign rd_ok_c   = (rd_addr_c < MEM_BYTES);
  assign rd_word_c = rd_ok_c ? mem[rd_addr_c[IW+1:2]] : '0;

  // Read FSM next-state and register inputs.
  always_comb begin
    r_next   = r_state;
    r_cmd_d  = r_cmd;
    r_addr_d = r_addr;
    r_cnt_d  = r_cnt;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    unique case (r_state)
      R_IDLE: if (bus.arvalid && arready_q) begin
        r_cmd_d  = '{id: bus.arid, len: bus.arlen, size: bus.arsize, burst: bus.arburst};
        r_addr_d = bus.araddr;
        r_cnt_d  = '0;
        rdata_d  = rd_word_c;
        rresp_d  = rd_ok_c ? OKAY : SLVERR;
        rlast_d  = (bus.arlen == '0);
        rid_d    = bus.arid;
        r_next   = R_DATA;
      end
      R_DATA: if (bus.rready && rvalid_q) begin
        if (rlast_q) begin
          rlast_d = 1'b0;
          r_next  = R_IDLE;
        end else begin
          r_addr_d = r_addr_nxt_c;
          r_cnt_d  = r_cnt + 4'd1;
          rdata_d  = rd_word_c;
          rresp_d  = rd_ok_c ? OKAY : SLVERR;
          rlast_d  = ((r_cnt + 4'd1) == r_cmd.len);
          rid_d    = r_cmd.id;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
    end else begin
      r_state   <= r_next;
      r_cmd     <= r_cmd_d;
      r_addr    <= r_addr_d;
      r_cnt     <= r_cnt_d;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rid     = rid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; only 32 is supported.
REQ-003 Parameter MEM_WORDS, default 256, depth of the internal word-addressed memory.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
REQ-005 Write address channel:
- awvalid in 1, awid in 4, awaddr in AW, awlen in 4, awsize in 3, awburst in 2.
- awready out 1.
REQ-006 Write data channel:
- wvalid in 1, wdata in DW, wstrb in 4, wlast in 1.
- wready out 1.
REQ-007 Write response channel:
- bvalid out 1, bid out 4.
- bready in 1.
REQ-008 Read address channel:
- arvalid in 1, arid in 4, araddr in AW, arlen in 4, arsize in 3, arburst in 2.
- arready out 1.
REQ-009 Read data channel:
- rvalid out 1, rdata out DW, rid out 4, rlast out 1, rresp out 2.
- rready in 1.

Function
REQ-010 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP:
- awready=1 only in W_IDLE.
- An AW handshake latches id, addr, len, size and burst, then moves to W_DATA.
REQ-011 In W_DATA, wready=1:
- Each W handshake writes byte lanes whose wstrb bit is 1 into mem[addr[AW-1:2] mod MEM_WORDS].
- The beat counter advances on each handshake.
- Beat awlen+1 ends the burst regardless of wlast; wlast is not used for termination.
REQ-012 The cycle after the last W handshake, bvalid=1 and bid=latched awid (W_RESP):
- bvalid, bid stay stable until bready=1.
- The handshake returns to W_IDLE; the next awready is asserted one cycle later.
REQ-013 Read FSM SHALL use states R_IDLE, R_DATA:
- arready=1 only in R_IDLE.
- An AR handshake in cycle N gives rvalid=1 in cycle N+1.
REQ-014 In R_DATA:
- rdata = mem word at the current beat address.
- rid = latched arid.
- rlast=1 exactly on beat arlen.
- rvalid, rdata, rid, rlast, rresp are held stable while rready=0.
- A handshake on the rlast beat returns to R_IDLE.
REQ-015 Burst address generation, with a byte step of 1<<size:
- FIXED (00): address constant.
- INCR (01) and reserved (11): address += step.
- WRAP (10): address wraps within a (len+1)*step aligned boundary; len+1 not in {2,4,8,16} is treated as INCR.
REQ-016 Byte addresses at or above MEM_WORDS*4:
- Reads return rresp=SLVERR (10) and rdata=0; otherwise rresp=OKAY (00).
- Writes to these addresses are discarded.
REQ-017 Read and write channels SHALL operate concurrently. A same-word read and write in the same cycle returns the pre-write data.
REQ-018 Address, length and ID counters SHALL be 4-bit and AW-bit. Address arithmetic wraps modulo 2^AW.

Reset
REQ-019 While aresetn=0:
- awready, wready, bvalid, arready, rvalid, rlast = 0.
- bid, rid, rdata, rresp = 0.
- Both FSMs are in their IDLE states.
REQ-020 bvalid and rvalid SHALL be 0 in the first cycle after aresetn rises; awready and arready are 1 in that cycle.
REQ-021 Reset mid-burst SHALL abort both FSMs immediately. Memory contents are not reset.

Structure
REQ-022 Package axi_slv_pkg SHALL hold:
- Burst type constants FIXED, INCR, WRAP.
- Response codes OKAY, SLVERR.
- The write_state_t and read_state_t enums.
REQ-023 Sub-module axi_burst_addr_gen (combinational next-address from addr, size, len, burst) SHALL be instantiated once per direction.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release: bvalid=0 and rvalid=0 the first cycle; awready=1 and arready=1.
- INCR write: awaddr=0x10, awlen=3, data 0xA0..0xA3 with wstrb=F -> bvalid one cycle after the 4th beat with bid=awid. INCR read of the same range -> 0xA0..0xA3, rlast on beat 3, rresp=OKAY.
- WRAP read: araddr=0x08, arlen=3, size=2 -> word addresses 0x08, 0x0C, 0x00, 0x04.
- Byte strobe: write 0x11223344 to 0x20 with wstrb=F, then 0xFFFFFFFF with wstrb=0100 -> read 0x11FF3344.
- Backpressure: rready=0 for 3 cycles mid-burst and bready=0 for 2 cycles -> rdata, rid, rlast, bvalid, bid stable throughout.
- Out-of-range: araddr=MEM_WORDS*4 -> rresp=10, rdata=0. Reset asserted mid write burst -> all outputs 0, and a subsequent fresh burst completes normally.
